// File: rtl/alu_result_fifo.sv
// alu_result_fifo: buffers results from the 12-bit ALU in a small
// first-word-fall-through FIFO. It also keeps debug counters for results
// that were dropped and for stored results that had the overflow flag set.
//
// Handshake: an entry moves out of the FIFO (pop) on a rising edge where
// o_valid and i_ready are both 1. While o_valid=1, o_data and o_overflow hold
// steady until that entry is popped. The ALU side has no ready signal, so a
// result arriving while the FIFO is full and nothing is popped is dropped.
// Every drop is recorded in o_drop and o_drop_cnt.
module alu_result_fifo #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_overflow,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_overflow,
  input  logic              i_ready,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_drop,
  output logic [7:0]        o_drop_cnt,
  output logic [7:0]        o_ovf_cnt
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  // Each entry stores {overflow, data}.
  logic [DATA_W:0]   mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              pop;
  logic              push;
  logic              lost;
  logic              flush;

  assign flush   = i_rst | i_clear;
  assign o_full  = (count == FULL_COUNT);
  assign o_empty = (count == '0);
  assign o_count = count;
  assign o_valid = ~o_empty;

  // A full FIFO still accepts a result when the head leaves in the same cycle.
  assign pop  = o_valid & i_ready;
  assign push = i_valid & (~o_full | pop);
  assign lost = i_valid & ~push;

  // Head entry is presented directly. It is forced to zero when the FIFO is empty.
  always_comb begin
    o_data     = '0;
    o_overflow = 1'b0;
    if (!o_empty) begin
      o_data     = mem[rd_ptr][DATA_W-1:0];
      o_overflow = mem[rd_ptr][DATA_W];
    end
  end

  // Storage write. Memory is not cleared; a flush cycle discards the write.
  always_ff @(posedge i_clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= {i_overflow, i_data};
    end
  end

  // Pointers and occupancy. Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge i_clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Debug: sticky drop flag and saturating drop/overflow counters.
  always_ff @(posedge i_clk) begin
    if (flush) begin
      o_drop     <= 1'b0;
      o_drop_cnt <= 8'd0;
      o_ovf_cnt  <= 8'd0;
    end else begin
      if (lost) begin
        o_drop <= 1'b1;
        if (o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
      end
      if (push && i_overflow && (o_ovf_cnt != 8'hFF)) begin
        o_ovf_cnt <= o_ovf_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: applies directed scenarios and then random traffic to
// alu_result_fifo. The results are compared against a queue-based model of
// the FIFO contents and the debug counters.
module tb_alu_result_fifo;

  localparam int DATA_W = 12;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst, clear, valid, ovf, ready;
  logic [DATA_W-1:0] data;
  logic              o_valid, o_overflow, o_full, o_empty, o_drop;
  logic [DATA_W-1:0] o_data;
  logic [ADDR_W:0]   o_count;
  logic [7:0]        o_drop_cnt, o_ovf_cnt;

  always #5 clk = ~clk;

  alu_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_clear(clear),
    .i_valid(valid), .i_data(data), .i_overflow(ovf),
    .o_valid(o_valid), .o_data(o_data), .o_overflow(o_overflow),
    .i_ready(ready), .o_full(o_full), .o_empty(o_empty), .o_count(o_count),
    .o_drop(o_drop), .o_drop_cnt(o_drop_cnt), .o_ovf_cnt(o_ovf_cnt)
  );

  // ---------------- reference model ----------------
  logic [DATA_W:0] exp_q[$];   // {overflow, data}, head at index 0
  logic            m_drop;
  int              m_drop_cnt, m_ovf_cnt;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply the model's view of one clock edge, given the inputs for that edge.
  task automatic model_edge();
    bit do_pop, do_push;
    if (rst || clear) begin
      exp_q.delete();
      m_drop = 1'b0; m_drop_cnt = 0; m_ovf_cnt = 0;
    end else begin
      do_pop  = (exp_q.size() > 0) && ready;
      do_push = valid && ((exp_q.size() < DEPTH) || do_pop);
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) begin
        exp_q.push_back({ovf, data});
        if (ovf && m_ovf_cnt < 255) m_ovf_cnt++;
      end
      if (valid && !do_push) begin
        m_drop = 1'b1;
        if (m_drop_cnt < 255) m_drop_cnt++;
      end
    end
  endtask

  task automatic check_outputs();
    logic [DATA_W:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    check_eq("o_valid",    32'(o_valid),    32'(exp_q.size() > 0));
    check_eq("o_data",     32'(o_data),     32'(head[DATA_W-1:0]));
    check_eq("o_overflow", 32'(o_overflow), 32'(head[DATA_W]));
    check_eq("o_count",    32'(o_count),    32'(exp_q.size()));
    check_eq("o_full",     32'(o_full),     32'(exp_q.size() == DEPTH));
    check_eq("o_empty",    32'(o_empty),    32'(exp_q.size() == 0));
    check_eq("o_drop",     32'(o_drop),     32'(m_drop));
    check_eq("o_drop_cnt", 32'(o_drop_cnt), 32'(m_drop_cnt));
    check_eq("o_ovf_cnt",  32'(o_ovf_cnt),  32'(m_ovf_cnt));
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of inputs, advance the model, clock, then check #1 after the edge.
  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic o,
                      input logic rdy, input logic clr, input logic r);
    valid = v; data = d; ovf = o; ready = rdy; clear = clr; rst = r;
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    valid = 0; data = '0; ovf = 0; ready = 0; clear = 0; rst = 1;
    #1;

    // 1. reset held for two cycles
    step(0, '0, 0, 0, 0, 1);
    step(0, '0, 0, 0, 0, 1);
    check_eq("rst_empty", 32'(o_empty), 32'd1);
    check_eq("rst_data",  32'(o_data),  32'd0);

    // 2. fill with 0x001..0x008, then drain in order
    for (int i = 1; i <= 8; i++) step(1, DATA_W'(i), 0, 0, 0, 0);
    check_eq("fill_full",  32'(o_full),  32'd1);
    check_eq("fill_count", 32'(o_count), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      check_eq("drain_order", 32'(o_data), 32'(i));
      step(0, '0, 0, 1, 0, 0);
    end
    check_eq("drain_empty", 32'(o_empty), 32'd1);

    // 3. drop while full
    for (int i = 1; i <= 8; i++) step(1, DATA_W'(i), 0, 0, 0, 0);
    step(1, 12'h7FF, 0, 0, 0, 0);
    step(1, 12'h7FF, 0, 0, 0, 0);
    check_eq("drop_flag",  32'(o_drop),     32'd1);
    check_eq("drop_cnt",   32'(o_drop_cnt), 32'd2);
    check_eq("drop_count", 32'(o_count),    32'd8);
    check_eq("drop_head",  32'(o_data),     32'h001);

    // 4. full pass-through: push and pop together
    step(1, 12'h123, 0, 1, 0, 0);
    check_eq("pass_head",  32'(o_data),     32'h002);
    check_eq("pass_count", 32'(o_count),    32'd8);
    check_eq("pass_drops", 32'(o_drop_cnt), 32'd2);
    for (int i = 0; i < 7; i++) step(0, '0, 0, 1, 0, 0);
    check_eq("pass_tail", 32'(o_data), 32'h123);
    step(0, '0, 0, 1, 0, 0);

    // 5. overflow counting across pointer wrap
    step(0, '0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) step(1, DATA_W'(12'h100 + i), (i % 3) == 2, 1, 0, 0);
    check_eq("ovf_cnt", 32'(o_ovf_cnt), 32'd6);
    step(0, '0, 0, 1, 0, 0);

    // 6. clear mid-stream, colliding with a push
    for (int i = 0; i < 5; i++) step(1, DATA_W'(12'h0A0 + i), 1, 0, 0, 0);
    step(1, 12'h555, 1, 0, 1, 0);
    check_eq("clr_count", 32'(o_count),   32'd0);
    check_eq("clr_empty", 32'(o_empty),   32'd1);
    check_eq("clr_drop",  32'(o_drop),    32'd0);
    check_eq("clr_ovf",   32'(o_ovf_cnt), 32'd0);

    // random traffic with occasional clear/reset
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, DATA_W'($urandom), $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 149) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule
